// File: rtl/pq_sched_ctrl.sv
// Purpose : front-end controller for the PDES event priority heap. Round-robin
//           arbitrates core enqueues, serialises heap ops, keeps the heap minimum
//           staged in a one-entry output register for the dispatcher.
// Latency : ENQ grant t -> pq_enq t+1 -> pq_deq t+3 -> out_valid t+4 (empty system);
//           DEQ decision c -> out_valid c+2.
// Backpr. : out_ready=0 holds out_data and suppresses DEQ; a full heap holds
//           enq_ready at 0 until a DEQ frees a slot.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset (shared with heap)
//   enq_valid/enq_data      per-core enqueue request; core i at [i*WIDTH +: WIDTH]
//   enq_ready               one-hot combinational grant in the decision cycle
//   out_valid/out_data      staged minimum event; out_ready consumes it
//   pq_enq/pq_deq           registered heap op strobes (at most one high)
//   pq_inp_data             registered heap input event
//   pq_out_data             heap root, captured on the cycle pq_deq is high
//   pq_elem_cnt             heap element count, cross-checked against q_count
//   q_count                 shadow heap occupancy
module pq_sched_ctrl #(
  parameter int WIDTH     = 32,
  parameter int CMP_WID   = 32,
  parameter int DEPTH     = 5,
  parameter int NUM_CORES = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_CORES-1:0]       enq_valid,
  input  logic [NUM_CORES*WIDTH-1:0] enq_data,
  output logic [NUM_CORES-1:0]       enq_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic                       pq_enq,
  output logic                       pq_deq,
  output logic [WIDTH-1:0]           pq_inp_data,
  input  logic [WIDTH-1:0]           pq_out_data,
  input  logic [DEPTH-1:0]           pq_elem_cnt,
  output logic [DEPTH-1:0]           q_count
);

  localparam int               PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  // Heap capacity 2^DEPTH-1 is the all-ones value of a DEPTH-bit counter.
  localparam logic [DEPTH-1:0] MAXQ  = {DEPTH{1'b1}};

  typedef enum logic [1:0] {
    OP_NONE = 2'd0,
    OP_ENQ  = 2'd1,
    OP_DEQ  = 2'd2
  } op_e;

  // Decision for the current cycle and the op currently on the heap port.
  op_e              dec_op;
  op_e              cur_op;

  logic [PTR_W-1:0] rr_ptr;
  logic             alt_flag;

  // Arbiter results
  logic             gnt_found;
  logic [PTR_W-1:0] gnt_idx;
  logic [WIDTH-1:0] gnt_data;
  int               cand_idx;

  // Candidate / legality terms
  logic             slot_free;
  logic             enq_cand;
  logic             deq_cand;

  // Occupancy one cycle late, lined up with the heap's own count.
  logic [DEPTH-1:0] q_count_d;

  // The strobes are the registered form of the previous decision.
  always_comb begin
    cur_op = OP_NONE;
    if (pq_enq) begin
      cur_op = OP_ENQ;
    end else if (pq_deq) begin
      cur_op = OP_DEQ;
    end
  end

  // Round-robin search starting at rr_ptr; the first valid core wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand_idx  = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      cand_idx = (int'(rr_ptr) + k) % NUM_CORES;
      if (!gnt_found && enq_valid[cand_idx]) begin
        gnt_found = 1'b1;
        gnt_idx   = PTR_W'(cand_idx);
      end
    end
  end

  // Constant-base mux of the granted core's event word.
  always_comb begin
    gnt_data = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      if (gnt_idx == PTR_W'(k)) begin
        gnt_data = enq_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // The output slot can take a new event if it is empty or being drained now.
  // A DEQ whose root is not yet captured shows up as cur_op == OP_DEQ, which
  // already blocks another DEQ, so it never double-books the slot.
  always_comb begin
    slot_free = !out_valid || out_ready;
    enq_cand  = gnt_found && (q_count != MAXQ) && (cur_op != OP_DEQ);
    deq_cand  = slot_free && (q_count != '0) && (cur_op == OP_NONE);
  end

  // DEQ normally wins; the alternate flag hands one decision to a waiting
  // enqueue after each DEQ so cores cannot be starved by continuous dispatch.
  always_comb begin
    dec_op = OP_NONE;
    if (deq_cand && !(alt_flag && enq_cand)) begin
      dec_op = OP_DEQ;
    end else if (enq_cand) begin
      dec_op = OP_ENQ;
    end
  end

  always_comb begin
    enq_ready = '0;
    for (int k = 0; k < NUM_CORES; k++) begin
      enq_ready[k] = (dec_op == OP_ENQ) && (gnt_idx == PTR_W'(k));
    end
  end

  // Heap op register, shadow occupancy, arbitration state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pq_enq      <= 1'b0;
      pq_deq      <= 1'b0;
      pq_inp_data <= '0;
      q_count     <= '0;
      rr_ptr      <= '0;
      alt_flag    <= 1'b0;
    end else begin
      pq_enq <= (dec_op == OP_ENQ);
      pq_deq <= (dec_op == OP_DEQ);
      case (dec_op)
        OP_ENQ: begin
          pq_inp_data <= gnt_data;
          q_count     <= q_count + DEPTH'(1);
          rr_ptr      <= (gnt_idx == PTR_W'(NUM_CORES - 1)) ? '0 : gnt_idx + PTR_W'(1);
          alt_flag    <= 1'b0;
        end
        OP_DEQ: begin
          q_count <= q_count - DEPTH'(1);
          if (|enq_valid) begin
            alt_flag <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // Output register: the heap root is valid while pq_deq is high and is
  // captured at the end of that cycle. The slot was already free then.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (pq_deq) begin
      out_valid <= 1'b1;
      out_data  <= pq_out_data;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  // The heap's count lags the shadow count by one cycle (it updates at the
  // end of the op cycle, the shadow at the end of the decision cycle).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_count_d <= '0;
    end else begin
      q_count_d <= q_count;
      assert (CMP_WID <= WIDTH);
      assert (q_count_d == pq_elem_cnt);
    end
  end

endmodule
